// File: rtl/rel_display_pkg.sv
// Shared types and constants for the time-of-day display reader.
package rel_display_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONV_MIN  = 2'd1,
    CONV_HOUR = 2'd2,
    LOAD      = 2'd3
  } state_t;

  // What a display digit register shows: a BCD digit, a dash or nothing.
  typedef enum logic [1:0] {
    SHOW_NUM   = 2'd0,
    SHOW_DASH  = 2'd1,
    SHOW_BLANK = 2'd2
  } show_t;

  typedef struct packed {
    show_t      show;
    logic [3:0] code;
  } digit_t;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [5:0] MIN_MAX    = 6'd59;
  localparam logic [4:0] HOUR24_MAX = 5'd23;
  localparam logic [4:0] HOUR12_MAX = 5'd11;

  // Shift-add-3 correction applied to both BCD nibbles before each shift.
  function automatic logic [7:0] dd_adjust(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

endpackage

// File: rtl/rel_display_if.sv
// Bundle between the clock core, the display reader and the board pins.
// There is no handshake: the time fields are level signals sampled on every
// clk edge while the reader is idle; seg/an/dp/busy are registered or decoded
// from registered state and are valid on every cycle.
interface rel_display_if;
  import rel_display_pkg::*;

  logic [5:0] minutos;
  logic [4:0] hora;
  logic       modo;
  logic       am;
  logic       pm;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;
  state_t     dbg_state;

  modport master (
    output minutos, hora, modo, am, pm,
    input  seg, an, dp, busy, dbg_state
  );

  modport slave (
    input  minutos, hora, modo, am, pm,
    output seg, an, dp, busy, dbg_state
  );
endinterface

// File: rtl/rel_display_seg7_dec.sv
// 7-segment decoder: BCD digit, with blank taking priority over dash.
module seg7_dec
  import rel_display_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  // Pure lookup; non-decimal codes never reach here and decode as blank.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (dash) begin
      seg = SEG_DASH;
    end else begin
      unique case (code)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/rel_display.sv
// Time display reader: snapshot, sequential binary-to-BCD conversion and
// 4-digit multiplexed 7-segment scan.
module rel_display
  import rel_display_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input logic          clk,
  input logic          rst,
  rel_display_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  state_t     state, state_nx;
  logic       valid;
  logic [5:0] snap_min;
  logic [4:0] snap_hour;
  logic       snap_modo, snap_pm;
  logic [2:0] bit_cnt;
  logic [5:0] shreg;
  logic [7:0] acc, acc_adj, min_bcd;
  logic [4:0] hour_adj;
  logic       pm_eff, changed, min_bad, hour_bad;
  digit_t [3:0] disp;
  logic       disp_modo, disp_pm;

  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       idx, idx_nx;
  logic             wrap;
  digit_t           cur;
  logic [6:0]       seg_nx;

  // am and pm both set (or both clear) is contradictory and reads as not-pm.
  assign pm_eff   = bus.pm & ~bus.am;
  assign changed  = !valid || ({bus.minutos, bus.hora, bus.modo, pm_eff} !=
                               {snap_min, snap_hour, snap_modo, snap_pm});
  assign acc_adj  = dd_adjust(acc);
  assign hour_adj = (!snap_modo && snap_hour == 5'd0) ? 5'd12 : snap_hour;
  assign min_bad  = snap_min > MIN_MAX;
  assign hour_bad = snap_modo ? (snap_hour > HOUR24_MAX) : (snap_hour > HOUR12_MAX);

  assign bus.busy      = (state != IDLE);
  assign bus.dbg_state = state;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state: fixed-length pass once a change is seen in IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (changed) state_nx = CONV_MIN;
      CONV_MIN:  if (bit_cnt == 3'd5) state_nx = CONV_HOUR;
      CONV_HOUR: if (bit_cnt == 3'd4) state_nx = LOAD;
      LOAD:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Snapshot capture, double-dabble engine and atomic display load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid     <= 1'b0;
      snap_min  <= '0;
      snap_hour <= '0;
      snap_modo <= 1'b0;
      snap_pm   <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      acc       <= '0;
      min_bcd   <= '0;
      disp      <= {4{digit_t'{SHOW_BLANK, 4'd0}}};
      disp_modo <= 1'b0;
      disp_pm   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (changed) begin
            valid     <= 1'b1;
            snap_min  <= bus.minutos;
            snap_hour <= bus.hora;
            snap_modo <= bus.modo;
            snap_pm   <= pm_eff;
            shreg     <= bus.minutos;
            acc       <= '0;
            bit_cnt   <= '0;
          end
        end
        CONV_MIN: begin
          acc     <= {acc_adj[6:0], shreg[5]};
          shreg   <= {shreg[4:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd5) begin
            // Park the minutes result and prime the engine with the hour.
            min_bcd <= {acc_adj[6:0], shreg[5]};
            acc     <= '0;
            shreg   <= {hour_adj, 1'b0};
            bit_cnt <= '0;
          end
        end
        CONV_HOUR: begin
          acc     <= {acc_adj[6:0], shreg[5]};
          shreg   <= {shreg[4:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        LOAD: begin
          disp[0] <= min_bad ? digit_t'{SHOW_DASH, 4'd0} : digit_t'{SHOW_NUM, min_bcd[3:0]};
          disp[1] <= min_bad ? digit_t'{SHOW_DASH, 4'd0} : digit_t'{SHOW_NUM, min_bcd[7:4]};
          disp[2] <= hour_bad ? digit_t'{SHOW_DASH, 4'd0} : digit_t'{SHOW_NUM, acc[3:0]};
          if (hour_bad)              disp[3] <= digit_t'{SHOW_DASH, 4'd0};
          else if (acc[7:4] == 4'd0) disp[3] <= digit_t'{SHOW_BLANK, 4'd0};
          else                       disp[3] <= digit_t'{SHOW_NUM, acc[7:4]};
          disp_modo <= snap_modo;
          disp_pm   <= snap_pm;
        end
        default: ;
      endcase
    end
  end

  assign wrap   = (scan_cnt == SCAN_LAST);
  assign idx_nx = wrap ? idx + 2'd1 : idx;
  assign cur    = disp[idx_nx];

  seg7_dec u_dec (
    .code  (cur.code),
    .blank (cur.show == SHOW_BLANK),
    .dash  (cur.show == SHOW_DASH),
    .seg   (seg_nx)
  );

  // Free-running digit scan; seg/dp registered alongside an.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      bus.an   <= 4'b0001;
      bus.seg  <= SEG_BLANK;
      bus.dp   <= 1'b0;
    end else begin
      scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
      idx      <= idx_nx;
      bus.an   <= 4'b0001 << idx_nx;
      bus.seg  <= seg_nx;
      bus.dp   <= (idx_nx == 2'd0) && !disp_modo && disp_pm;
    end
  end

endmodule
